fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that owns the program counter and drives the byte address of the instruction memory `ins_mem`. It accounts for the memory's one-cycle read latency and presents a valid/pc/instruction triple to decode. It honours decode stalls and execute-stage redirects (branches and jumps), and latches a sticky fault on illegal or out-of-range fetch targets.

---
 rtl/fetch_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC (F), issues byte addresses to a one-cycle-latency instruction
// memory and presents a valid/pc/instr triple to decode. Handles decode
// stalls with a hold buffer, execute redirects with a one-bubble flush, and
// latches a sticky fault on illegal redirect targets or sequential overrun.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INS      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  // Highest legal word address in ins_mem.
  localparam logic [31:0] LAST_PC = 32'(4 * INS - 4);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] f_q;
  logic        dv_q;
  logic [31:0] dpc_q;
  logic [31:0] hinstr_q;
  logic        fault_q;
  logic [31:0] cnt_q;

  logic        redir_bad;
  logic        accept;
  logic        at_last;

  // Classify the redirect target and detect an accepted delivery.
  always_comb begin
    redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);
    accept    = dv_q && !stall && !redirect_valid;
    at_last   = (f_q == LAST_PC);
  end

  // Fetch FSM: PC, in-flight slot, hold buffer, sticky fault and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      f_q      <= RESET_PC;
      dv_q     <= 1'b0;
      dpc_q    <= 32'h0;
      hinstr_q <= 32'h0;
      fault_q  <= 1'b0;
      cnt_q    <= 32'h0;
    end else begin
      // Counting is state-independent: a delivery is consumed whenever decode
      // takes it and no redirect flushes it on the same edge.
      if (accept) cnt_q <= cnt_q + 32'd1;

      case (state_q)
        S_RUN, S_STALL: begin
          if (redirect_valid) begin
            // Redirect wins over stall and flushes whatever is shown.
            dv_q <= 1'b0;
            if (redir_bad) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              f_q     <= redirect_pc;
              state_q <= S_RUN;
            end
          end else if (!stall) begin
            // Advance. During a stall memory kept addressing F, so the
            // next mem_rdata already belongs to the new D_pc.
            dpc_q <= f_q;
            dv_q  <= 1'b1;
            if (at_last) begin
              // Last word still gets delivered; F does not walk off the end.
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end else begin
              f_q     <= f_q + 32'd4;
              state_q <= S_RUN;
            end
          end else if (state_q == S_RUN && dv_q) begin
            // First stalled cycle: mem_rdata is still instr(D_pc) now, but
            // next cycle it will be instr(F), so capture it.
            hinstr_q <= mem_rdata;
            state_q  <= S_STALL;
          end
        end
        S_FAULT: begin
          // F is frozen and redirects are ignored; only drain D.
          if (!stall) dv_q <= 1'b0;
        end
        default: state_q <= S_FAULT;
      endcase
    end
  end

  assign mem_addr  = f_q;
  assign if_valid  = dv_q;
  assign if_pc     = dpc_q;
  assign if_instr  = (state_q == S_STALL) ? hinstr_q : mem_rdata;
  assign fault     = fault_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with a small program-order
// reference model and a one-cycle-latency memory model.
module tb_fetch_ctrl;

  localparam int          INS      = 16;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] LAST     = 32'(4 * INS - 4);
  localparam int          AW       = $clog2(INS);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        fault;
  logic [31:0] fetch_cnt;

  fetch_ctrl #(.RESET_PC(RESET_PC), .INS(INS)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .fault(fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle read latency.
  logic [31:0] mem [INS];
  always @(posedge clk)
    mem_rdata <= (mem_addr <= LAST) ? mem[mem_addr[AW+1:2]] : 32'h0;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 1'b0;

  // Reference model: where fetch will go next, what decode is being shown,
  // whether we are faulted, and how many deliveries were consumed.
  logic [31:0] m_nxt;
  logic        m_sv;
  logic [31:0] m_spc;
  logic        m_flt;
  logic [31:0] m_cnt;
  logic [63:0] sbq [$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_nxt = RESET_PC; m_sv = 1'b0; m_spc = 32'h0; m_flt = 1'b0; m_cnt = 32'h0;
    sbq.delete();
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [31:0] rp);
    if (m_sv && !st && !rv) m_cnt = m_cnt + 1;
    if (m_flt) begin
      if (!st) m_sv = 1'b0;
    end else if (rv) begin
      m_sv = 1'b0;
      if (rp[1:0] == 2'b00 && rp <= LAST) m_nxt = rp;
      else m_flt = 1'b1;
    end else if (!st) begin
      m_spc = m_nxt;
      m_sv  = 1'b1;
      if (m_nxt == LAST) m_flt = 1'b1;
      else m_nxt = m_nxt + 4;
    end
  endtask

  // One bus cycle: drive inputs, book an expected delivery if decode takes
  // the shown instruction, then advance the model at the edge.
  task automatic cycle(input logic st, input logic rv, input logic [31:0] rp);
    logic [31:0] w;
    stall = st; redirect_valid = rv; redirect_pc = rp;
    if (m_sv && !st && !rv) begin
      w = mem[m_spc[AW+1:2]];
      sbq.push_back({m_spc, w});
    end
    @(posedge clk);
    model_step(st, rv, rp);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_init();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares visible outputs to the model and pops the scoreboard
  // on every delivery decode consumes.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] w;
    if (mon_en) begin
      chk("if_valid", 64'(if_valid), 64'(m_sv));
      chk("mem_addr", 64'(mem_addr), 64'(m_nxt));
      chk("fault", 64'(fault), 64'(m_flt));
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
      if (m_sv) begin
        w = mem[m_spc[AW+1:2]];
        chk("if_pc", 64'(if_pc), 64'(m_spc));
        chk("if_instr", 64'(if_instr), 64'(w));
      end
      if (if_valid && !stall && !redirect_valid) begin
        if (sbq.size() == 0) begin
          checks++; fails++;
          $display("FAIL sb_empty got=delivery pc=%h exp=none", if_pc);
        end else begin
          e = sbq.pop_front();
          chk("sb_delivery", {if_pc, if_instr}, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] rp;
    int r;
    mem[0] = 32'h0000_0513;
    mem[1] = 32'h00c0_0593;
    mem[2] = 32'h0085_8613;
    for (int i = 3; i < INS; i++) mem[i] = $urandom;

    // Reset state before the first edge after release.
    do_reset();
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'(RESET_PC));
    chk("rst_cnt", 64'(fetch_cnt), 64'd0);

    // First deliveries and a 3-cycle stall on pc 4.
    cycle(0, 0, 0);
    chk("tp_first", {31'h0, if_valid, if_pc, if_instr}, {31'h0, 1'b1, 32'h0, 32'h0000_0513});
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      chk("tp_stall_hold", {if_pc, if_instr}, {32'h4, 32'h00c0_0593});
    end
    cycle(0, 0, 0);
    chk("tp_after_stall", {if_pc, if_instr}, {32'h8, 32'h0085_8613});
    chk("tp_cnt_stall", 64'(fetch_cnt), 64'd2);

    // Redirect with stall also high: one bubble, flushed pc 8 not counted.
    cycle(1, 1, 32'h0C);
    chk("tp_redir_bubble", {31'h0, if_valid, mem_addr}, {31'h0, 1'b0, 32'h0C});
    cycle(0, 0, 0);
    chk("tp_redir_pc", 64'(if_pc), 64'h0C);
    chk("tp_redir_cnt", 64'(fetch_cnt), 64'd2);
    cycle(0, 0, 0);

    // Illegal (misaligned) redirect: fault, F frozen, later redirect ignored.
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 32'h06);
    chk("tp_bad_fault", {if_valid, fault}, {1'b0, 1'b1});
    cycle(0, 1, 32'h10);
    cycle(0, 0, 0);
    chk("tp_bad_frozen", 64'(mem_addr), 64'h4);

    // Sequential overrun from LAST-12.
    do_reset();
    cycle(0, 1, LAST - 12);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    chk("tp_overrun", {fault, if_valid, fetch_cnt}, {1'b1, 1'b0, 32'd4});

    // Asynchronous reset in the middle of a stall.
    do_reset();
    cycle(0, 0, 0); cycle(0, 0, 0); cycle(0, 0, 0);
    cycle(1, 0, 0); cycle(1, 0, 0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("tp_async_rst", {fault, if_valid, if_pc, mem_addr, fetch_cnt},
        {1'b0, 1'b0, 32'h0, RESET_PC, 32'h0});
    stall = 1'b0;
    @(posedge clk);
    #1;
    model_init();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cycle(0, 0, 0);
    chk("tp_restart", {31'h0, if_valid, if_pc}, {31'h0, 1'b1, RESET_PC});

    // Randomized blocks, each starting from reset.
    for (int b = 0; b < 6; b++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        r = $urandom_range(0, 39);
        if (r == 0)      rp = 32'($urandom_range(0, INS - 1) * 4) | 32'h2;
        else if (r == 1) rp = 32'(4 * INS);
        else if (r < 8)  rp = LAST - 32'($urandom_range(0, 2) * 4);
        else             rp = 32'($urandom_range(0, INS - 1) * 4);
        cycle(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0, rp);
      end
      chk("sb_drained", 64'(sbq.size()), 64'd0);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
